// File: rtl/ponto_fixo_acc_8.sv
// Fixed-point block accumulator: sums LEN = 2^LOG2_LEN unsigned Qm.n products, then saturates or truncates (mean instead when PONTO_FIXO_ACC_AVG_EN is defined).
// Latency: result valid the cycle after the LEN-th accepted sample.
// Backpressure: in_ready drops while a result waits in DONE; the result is held until out_ready.
module ponto_fixo_acc_8 #(
    parameter int N        = 8,
    parameter int LOG2_LEN = 2,
    parameter int SATURATE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_ovf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ovf,
    output logic         busy
);

    localparam int W = N + LOG2_LEN;
    localparam logic [LOG2_LEN-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t              state;
    logic [W-1:0]        acc;
    logic [W-1:0]        sum;
    logic [LOG2_LEN-1:0] cnt;
    logic                sticky;
    logic                accept;
    logic                ovf_next;
    logic [N-1:0]        res_dat;
    logic                res_ovf;

    assign accept   = in_valid && in_ready;
    assign sum      = acc + {{LOG2_LEN{1'b0}}, in_data};
    assign ovf_next = sticky | in_ovf;

    // Result of the block if the current sample is the last one.
    always_comb begin
        res_dat = sum[N-1:0];
        res_ovf = ovf_next;
`ifdef PONTO_FIXO_ACC_AVG_EN
        res_dat = sum[W-1:LOG2_LEN];
`else
        if (sum[W-1:N] != '0) begin
            res_dat = (SATURATE != 0) ? {N{1'b1}} : sum[N-1:0];
            res_ovf = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= {{LOG2_LEN{1'b0}}, in_data};
                        sticky <= in_ovf;
                        cnt    <= LOG2_LEN'(1);
                        state  <= ACC;
                        busy   <= 1'b1;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc    <= sum;
                        sticky <= ovf_next;
                        cnt    <= cnt + LOG2_LEN'(1);
                        if (cnt == CNT_LAST) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= res_dat;
                            out_ovf   <= res_ovf;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        sticky    <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_ovf   <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
